// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port, fixed-latency memory.
// Port 0 is the multicycle CPU, port 1 the loader/debug port. Each access runs
// IDLE -> BUSY (LAT cycles) -> DONE (one-cycle done pulse) -> IDLE.
// LAT must be 1 or more; a value of 0 has no meaningful memory cycle.
module mem_arbiter #(
   parameter int unsigned AW  = 5,
   parameter int unsigned DW  = 8,
   parameter int unsigned LAT = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0,
   input  logic          req1,
   input  logic          we0,
   input  logic          we1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic [DW-1:0] rdata0,
   output logic [DW-1:0] rdata1,
   output logic          done0,
   output logic          done1,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_re,
   output logic          mem_we,
   input  logic [DW-1:0] mem_rdata,
   output logic          owner,
   output logic          busy
);

   localparam int unsigned   CW       = (LAT > 1) ? $clog2(LAT) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(LAT - 1);

   typedef enum logic [1:0] {
      StIdle,
      StBusy,
      StDone
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          last;
   logic          we_l;

   logic          any_req;
   logic          grant1;
   logic          sel_we;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;

   // Round-robin pick: on a tie the port not served last wins.
   always_comb begin
      any_req   = req0 | req1;
      grant1    = req1 & (~req0 | ~last);
      sel_we    = grant1 ? we1    : we0;
      sel_addr  = grant1 ? addr1  : addr0;
      sel_wdata = grant1 ? wdata1 : wdata0;
   end

   // Access sequencer; every output is a register updated here.
   // mem_addr/mem_wdata double as the latched address/data of the access.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= StIdle;
         cnt       <= '0;
         last      <= 1'b1;
         we_l      <= 1'b0;
         owner     <= 1'b0;
         busy      <= 1'b0;
         done0     <= 1'b0;
         done1     <= 1'b0;
         mem_re    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rdata0    <= '0;
         rdata1    <= '0;
      end else begin
         unique case (state)
            StIdle: begin
               if (any_req) begin
                  state     <= StBusy;
                  busy      <= 1'b1;
                  owner     <= grant1;
                  cnt       <= CNT_INIT;
                  we_l      <= sel_we;
                  mem_addr  <= sel_addr;
                  mem_wdata <= sel_wdata;
                  mem_re    <= ~sel_we;
                  mem_we    <= sel_we;
               end
            end
            StBusy: begin
               // Writes strobe only in the first BUSY cycle.
               mem_we <= 1'b0;
               if (cnt == '0) begin
                  if (!we_l) begin
                     if (owner) begin
                        rdata1 <= mem_rdata;
                     end else begin
                        rdata0 <= mem_rdata;
                     end
                  end
                  last   <= owner;
                  mem_re <= 1'b0;
                  done0  <= ~owner;
                  done1  <= owner;
                  state  <= StDone;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            StDone: begin
               // Requests are ignored here; a held req re-arbitrates in IDLE.
               done0 <= 1'b0;
               done1 <= 1'b0;
               busy  <= 1'b0;
               state <= StIdle;
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two builds (LAT=2 and LAT=1), each with its own memory
// model. Transactions are queued per port and checked cycle by cycle against
// the access timeline and a reference memory / round-robin order.
module tb_mem_arbiter;

   typedef struct packed {
      logic       we;
      logic [4:0] addr;
      logic [7:0] wdata;
   } op_t;

   logic             clk;
   logic [1:0]       rst_v;
   logic [1:0]       req0_v, req1_v, we0_v, we1_v;
   logic [1:0][4:0]  addr0_v, addr1_v;
   logic [1:0][7:0]  wdata0_v, wdata1_v;
   logic [1:0][7:0]  rdata0_v, rdata1_v;
   logic [1:0]       done0_v, done1_v;
   logic [1:0][4:0]  mem_addr_v;
   logic [1:0][7:0]  mem_wdata_v;
   logic [1:0]       mem_re_v, mem_we_v;
   logic [1:0][7:0]  mem_rdata_v;
   logic [1:0]       owner_v, busy_v;

   logic [7:0] mem_m   [2][32];
   logic [7:0] ref_mem [2][32];
   logic [7:0] exp_rd  [2][2];
   bit         last_m  [2];
   int         re_run  [2];

   logic       poke_en;
   int         poke_i;
   logic [4:0] poke_a;
   logic [7:0] poke_d;

   op_t q_p0[$];
   op_t q_p1[$];

   int checks = 0;
   int errors = 0;

   mem_arbiter #(.AW(5), .DW(8), .LAT(2)) u_dut0 (
      .clk(clk), .rst(rst_v[0]),
      .req0(req0_v[0]), .req1(req1_v[0]), .we0(we0_v[0]), .we1(we1_v[0]),
      .addr0(addr0_v[0]), .addr1(addr1_v[0]), .wdata0(wdata0_v[0]), .wdata1(wdata1_v[0]),
      .rdata0(rdata0_v[0]), .rdata1(rdata1_v[0]), .done0(done0_v[0]), .done1(done1_v[0]),
      .mem_addr(mem_addr_v[0]), .mem_wdata(mem_wdata_v[0]), .mem_re(mem_re_v[0]),
      .mem_we(mem_we_v[0]), .mem_rdata(mem_rdata_v[0]), .owner(owner_v[0]), .busy(busy_v[0])
   );

   mem_arbiter #(.AW(5), .DW(8), .LAT(1)) u_dut1 (
      .clk(clk), .rst(rst_v[1]),
      .req0(req0_v[1]), .req1(req1_v[1]), .we0(we0_v[1]), .we1(we1_v[1]),
      .addr0(addr0_v[1]), .addr1(addr1_v[1]), .wdata0(wdata0_v[1]), .wdata1(wdata1_v[1]),
      .rdata0(rdata0_v[1]), .rdata1(rdata1_v[1]), .done0(done0_v[1]), .done1(done1_v[1]),
      .mem_addr(mem_addr_v[1]), .mem_wdata(mem_wdata_v[1]), .mem_re(mem_re_v[1]),
      .mem_we(mem_we_v[1]), .mem_rdata(mem_rdata_v[1]), .owner(owner_v[1]), .busy(busy_v[1])
   );

   function automatic int lat_of(input int i);
      return (i == 0) ? 2 : 1;
   endfunction

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: data is only correct in the LAT-th consecutive read cycle.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         if (mem_re_v[i] && re_run[i] == lat_of(i) - 1) begin
            mem_rdata_v[i] = mem_m[i][mem_addr_v[i]];
         end else begin
            mem_rdata_v[i] = ~mem_m[i][mem_addr_v[i]];
         end
      end
   end

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         re_run[i] <= mem_re_v[i] ? re_run[i] + 1 : 0;
         if (mem_we_v[i]) mem_m[i][mem_addr_v[i]] <= mem_wdata_v[i];
      end
      if (poke_en) mem_m[poke_i][poke_a] <= poke_d;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed no end, required finish before 500us");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic op_t rand_op();
      op_t o;
      o.we    = 1'($urandom_range(0, 1));
      o.addr  = 5'($urandom_range(0, 31));
      o.wdata = 8'($urandom_range(0, 255));
      return o;
   endfunction

   function automatic op_t mk_op(input logic we, input logic [4:0] a, input logic [7:0] d);
      op_t o;
      o.we = we; o.addr = a; o.wdata = d;
      return o;
   endfunction

   // Called at posedge+1; returns at the next posedge+1.
   task automatic poke(input int i, input logic [4:0] a, input logic [7:0] d);
      poke_en = 1'b1; poke_i = i; poke_a = a; poke_d = d;
      ref_mem[i][a] = d;
      @(posedge clk);
      #1 poke_en = 1'b0;
   endtask

   task automatic drive_port(input int i, input int p);
      op_t h;
      logic r;
      if (p == 0) begin
         r = (q_p0.size() != 0);
         h = r ? q_p0[0] : rand_op();
         req0_v[i] = r; we0_v[i] = h.we; addr0_v[i] = h.addr; wdata0_v[i] = h.wdata;
      end else begin
         r = (q_p1.size() != 0);
         h = r ? q_p1[0] : rand_op();
         req1_v[i] = r; we1_v[i] = h.we; addr1_v[i] = h.addr; wdata1_v[i] = h.wdata;
      end
   endtask

   task automatic model_reset(input int i);
      last_m[i]    = 1'b1;
      exp_rd[i][0] = 8'h00;
      exp_rd[i][1] = 8'h00;
   endtask

   task automatic chk_reset(input int i);
      chk("rst_rdata0", rdata0_v[i], 0);
      chk("rst_rdata1", rdata1_v[i], 0);
      chk("rst_done", {done1_v[i], done0_v[i]}, 0);
      chk("rst_mem_en", {mem_we_v[i], mem_re_v[i]}, 0);
      chk("rst_mem_addr", mem_addr_v[i], 0);
      chk("rst_mem_wdata", mem_wdata_v[i], 0);
      chk("rst_owner_busy", {owner_v[i], busy_v[i]}, 0);
   endtask

   // Called at posedge+1 in IDLE; runs both port queues to empty.
   task automatic run_engine(input int i);
      int  lat, per, cyc, ph, w, ndone, total;
      op_t cur;
      lat   = lat_of(i);
      per   = lat + 2;
      total = q_p0.size() + q_p1.size();
      drive_port(i, 0);
      drive_port(i, 1);
      cyc = 0; ndone = 0; w = 0; cur = '0;
      while (ndone < total && cyc < 400) begin
         @(negedge clk);
         ph = cyc % per;
         if (ph == 0) begin
            if (q_p0.size() != 0 && q_p1.size() != 0) w = last_m[i] ? 0 : 1;
            else w = (q_p0.size() != 0) ? 0 : 1;
            cur = (w == 0) ? q_p0[0] : q_p1[0];
            chk("idle_busy", busy_v[i], 0);
            chk("idle_done", {done1_v[i], done0_v[i]}, 0);
         end else if (ph <= lat) begin
            chk("busy", busy_v[i], 1);
            chk("owner", owner_v[i], w);
            chk("mem_addr", mem_addr_v[i], cur.addr);
            chk("mem_wdata", mem_wdata_v[i], cur.wdata);
            chk("mem_re", mem_re_v[i], !cur.we);
            chk("mem_we", mem_we_v[i], cur.we && ph == 1);
            chk("busy_done", {done1_v[i], done0_v[i]}, 0);
         end else begin
            chk("done_busy", busy_v[i], 1);
            chk("done_pulse", {done1_v[i], done0_v[i]}, (w == 1) ? 2 : 1);
            chk("done_mem_en", {mem_we_v[i], mem_re_v[i]}, 0);
            if (!cur.we) exp_rd[i][w] = ref_mem[i][cur.addr];
            else ref_mem[i][cur.addr] = cur.wdata;
            chk("rdata0", rdata0_v[i], exp_rd[i][0]);
            chk("rdata1", rdata1_v[i], exp_rd[i][1]);
            last_m[i] = (w == 1);
            if (w == 0) void'(q_p0.pop_front());
            else void'(q_p1.pop_front());
            ndone++;
            drive_port(i, w);
         end
         cyc++;
      end
      chk("engine_complete", ndone, total);
      q_p0.delete();
      q_p1.delete();
      drive_port(i, 0);
      drive_port(i, 1);
      @(negedge clk);
      chk("end_idle", {busy_v[i], done1_v[i], done0_v[i]}, 0);
      @(posedge clk);
      #1;
   endtask

   task automatic reset_pulse(input int i);
      rst_v[i] = 1'b0;
      #1 chk_reset(i);
      model_reset(i);
      @(posedge clk);
      #1 rst_v[i] = 1'b1;
   endtask

   task automatic random_rounds(input int i, input int n);
      int n0, n1;
      for (int r = 0; r < n; r++) begin
         n0 = $urandom_range(0, 3);
         n1 = $urandom_range(0, 3);
         if (n0 == 0 && n1 == 0) n0 = 1;
         for (int k = 0; k < n0; k++) q_p0.push_back(rand_op());
         for (int k = 0; k < n1; k++) q_p1.push_back(rand_op());
         run_engine(i);
      end
   endtask

   initial begin
      rst_v = 2'b00;
      poke_en = 1'b0; poke_i = 0; poke_a = '0; poke_d = '0;
      req0_v = '0; req1_v = '0; we0_v = '0; we1_v = '0;
      addr0_v = '0; addr1_v = '0; wdata0_v = '0; wdata1_v = '0;
      model_reset(0);
      model_reset(1);
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         for (int a = 0; a < 32; a++) poke(i, 5'(a), 8'($urandom_range(0, 255)));
      end
      chk_reset(0);
      chk_reset(1);
      rst_v = 2'b11;
      for (int i = 0; i < 2; i++) begin
         // Single read of a known location.
         poke(i, 5'h03, 8'hA5);
         q_p0.push_back(mk_op(1'b0, 5'h03, 8'h00));
         run_engine(i);
         chk("single_read_rdata0", rdata0_v[i], 8'hA5);
         chk("single_read_rdata1", rdata1_v[i], 8'h00);
         // Tie straight after reset: port 0 first, then port 1.
         reset_pulse(i);
         q_p0.push_back(rand_op());
         q_p1.push_back(rand_op());
         run_engine(i);
      end
      // Fairness under continuous load: owners alternate 0,1,0,1,0,1.
      for (int k = 0; k < 3; k++) begin
         q_p0.push_back(rand_op());
         q_p1.push_back(rand_op());
      end
      run_engine(0);
      // Write then read back across ports.
      q_p1.push_back(mk_op(1'b1, 5'h1F, 8'h5C));
      run_engine(0);
      q_p0.push_back(mk_op(1'b0, 5'h1F, 8'h00));
      run_engine(0);
      chk("readback_rdata0", rdata0_v[0], 8'h5C);
      // Reset in the first BUSY cycle of a port 0 read, req0 held throughout.
      q_p0.push_back(mk_op(1'b0, 5'($urandom_range(0, 31)), 8'h00));
      drive_port(0, 0);
      @(negedge clk);
      chk("midrst_idle", busy_v[0], 0);
      @(negedge clk);
      chk("midrst_busy", {busy_v[0], mem_re_v[0]}, 2'b11);
      rst_v[0] = 1'b0;
      #1 chk_reset(0);
      model_reset(0);
      @(posedge clk);
      #1 rst_v[0] = 1'b1;
      run_engine(0);
      random_rounds(0, 8);
      random_rounds(1, 8);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single-port data/instruction memory between the multicycle CPU (port 0) and a program loader / debug port (port 1). Each access is sequenced through a fixed-latency memory cycle: request, grant, address/data hold, read capture and a one-cycle completion pulse. When both ports request, round-robin fairness applies. The CPU controller holds its state while `done0` is low, which gives it a memory stall.

## Interface
- `AW`, 5, address width
- `DW`, 8, data width
- `LAT`, 2, memory access cycles per transfer; legal range is 1 or more, and 0 is illegal
- `clk`  in  1  single clock; all state changes on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `req0`, `req1`  in  1  access request; held by the requester until it sees `done`
- `we0`, `we1`  in  1  1 = write, 0 = read; held with `req`
- `addr0`, `addr1`  in  AW  access address; held with `req`
- `wdata0`, `wdata1`  in  DW  write data; held with `req`
- `rdata0`, `rdata1`  out  DW  read data register per port
- `done0`, `done1`  out  1  one-cycle completion pulse
- `mem_addr`  out  AW  memory address
- `mem_wdata`  out  DW  memory write data
- `mem_re`  out  1  memory read enable
- `mem_we`  out  1  memory write enable
- `mem_rdata`  in  DW  memory read data; valid at the end of the LAT-th enable cycle
- `owner`  out  1  port currently granted; meaningful only while `busy` = 1
- `busy`  out  1  high in the BUSY and DONE states

## Operation
- The FSM has three states: IDLE, BUSY and DONE.
- **IDLE, arbitration:**
  - Only `req0` high: grant port 0.
  - Only `req1` high: grant port 1.
  - Both high: grant the port not served last, tracked in register `last`.
  - On a grant: latch the winner's `addr`, `wdata` and `we` into internal registers, set `owner`, load `cnt` = LAT-1, and go to BUSY.
- **BUSY:**
  - `mem_addr` and `mem_wdata` are driven from the latched registers for the whole state.
  - Read: `mem_re` = 1 in every BUSY cycle.
  - Write: `mem_we` = 1 in the first BUSY cycle only.
  - `cnt` decrements each cycle.
  - In the cycle with `cnt` = 0:
    - Read: `mem_rdata` is captured into `rdata<owner>`.
    - Always: `last` is set to `owner` and the FSM goes to DONE.
- **DONE:**
  - `done<owner>` = 1 for exactly one cycle.
  - Request inputs are ignored.
  - Next state is always IDLE.
- `rdata0` and `rdata1` are each updated only by a read completing on that port. They hold their value otherwise, including across writes and across accesses by the other port.
- While not in BUSY, `mem_addr` and `mem_wdata` hold their last values, and `mem_re` = `mem_we` = 0.
- A requester that keeps `req` high after its `done` is treated as a new request in the following IDLE cycle. This is intended for back-to-back accesses.
- `cnt` width is clog2(LAT), with a minimum of 1 bit.
- **Reset (rst = 0), asynchronous, any state:**
  - FSM to IDLE.
  - `rdata0` = `rdata1` = 0.
  - `done0` = `done1` = 0.
  - `mem_re` = `mem_we` = 0.
  - `mem_addr` = 0, `mem_wdata` = 0.
  - `owner` = 0, `busy` = 0.
  - `last` = 1, so port 0 wins the first tie.
  - An in-flight read is abandoned. A write already issued is not undone.

## Timing
- Cycle 0: IDLE with `req` high, sampled at the end of the cycle.
- Cycles 1 to LAT: BUSY. `busy` = 1 and `mem_re` = 1 (read). `mem_we` = 1 in cycle 1 only (write).
- Cycle LAT+1: DONE. `done` = 1, and `rdata` already shows the new value.
- Cycle LAT+2: IDLE; a new grant is possible at the end of this cycle.
- Requester latency from `req` to `done` is LAT+1 cycles.
- Maximum throughput is one access per LAT+2 cycles.
- Requester `addr`, `wdata` and `we` may change once `done` has been seen; the arbiter uses its latched copies.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Single read:** LAT=2. Memory at 0x03 holds 0xA5. Port 0 requests a read of 0x03 → `mem_re` high for 2 cycles, `done0` on the 3rd cycle after the request, `rdata0` = 0xA5, `rdata1` unchanged at 0.
- **Tie after reset:** `req0` and `req1` rise in the same cycle → port 0 served first (`owner` = 0). Port 1 is granted in the IDLE cycle after `done0`, with `done1` arriving 4 cycles after `done0`.
- **Fairness under load:** both ports hold `req` continuously for 6 transfers → `owner` sequence 0,1,0,1,0,1, with exactly one `done` per LAT+2 cycles.
- **Write then read-back:** port 1 writes 0x5C to address 0x1F, then port 0 reads 0x1F → `mem_we` is a single-cycle pulse with `mem_addr` = 0x1F and `mem_wdata` = 0x5C, and `rdata0` = 0x5C.
- **Reset mid-read:** `rst` asserted in the 1st BUSY cycle of a port 0 read → all outputs are 0 immediately. After `rst` is released with `req0` still high, a fresh transfer completes in LAT+1 cycles.
- **LAT=1 build:** the single-read and tie scenarios are repeated → `done` arrives 2 cycles after `req` and a transfer completes every 3 cycles.
